// File: rtl/sr_pkg.sv
// Shared types and constants for the button-to-SR-latch driver.
// Holds the per-channel debounce state encoding and synchronizer depth.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } db_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter.
// Emits a single registered press event per accepted press.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  db_state_t              r_state;
  logic                   r_press;
  logic                   w_btn;

  assign w_btn   = r_sync[SYNC_STAGES-1];
  assign o_press = r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_btn) begin
            r_state <= PRESS_CHK;
            r_cnt   <= CW'(1);
          end
        end
        PRESS_CHK: begin
          if (r_cnt == CMAX) begin
            r_press <= 1'b1;
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (!w_btn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!w_btn) begin
            r_state <= REL_CHK;
            r_cnt   <= CW'(1);
          end
        end
        REL_CHK: begin
          if (r_cnt == CMAX) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_btn) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/button_sr_driver.sv
// Debounced set/reset buttons driving SR-latch pulses with arbitration.
// Define SR_DRIVER_MIRROR_EN to add the q_mirror latch-state output.
module button_sr_driver
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_LEN       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic conflict
`ifdef SR_DRIVER_MIRROR_EN
  ,
  output logic q_mirror
`endif
);

  localparam logic [7:0] PL = 8'(PULSE_LEN - 1);

  logic       w_ps;
  logic       w_pr;
  logic       r_s;
  logic       r_r;
  logic       r_conflict;
  logic [7:0] r_cnt;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_set),
    .o_press(w_ps)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_reset),
    .o_press(w_pr)
  );

  assign s        = r_s;
  assign r        = r_r;
  assign conflict = r_conflict;

  // A press on one channel is dropped while the other's pulse is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_conflict <= 1'b0;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 8'd1;
      end else begin
        r_s <= 1'b0;
        r_r <= 1'b0;
      end
      if (w_ps && w_pr) begin
        r_conflict <= 1'b1;
      end else if (w_ps) begin
        if (r_r) begin
          r_conflict <= 1'b1;
        end else begin
          r_s   <= 1'b1;
          r_cnt <= PL;
        end
      end else if (w_pr) begin
        if (r_s) begin
          r_conflict <= 1'b1;
        end else begin
          r_r   <= 1'b1;
          r_cnt <= PL;
        end
      end
    end
  end

`ifdef SR_DRIVER_MIRROR_EN
  logic r_q;

  assign q_mirror = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (w_ps && !w_pr && !r_r) begin
      r_q <= 1'b1;
    end else if (w_pr && !w_ps && !r_s) begin
      r_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_button_sr_driver.sv
// Directed bench for button_sr_driver with DEBOUNCE_CYCLES=4, PULSE_LEN=2.
// Cycle n means the value observed just after the n-th edge from press.
module tb_button_sr_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bs = 1'b0;
  logic br = 1'b0;
  logic s;
  logic r;
  logic conflict;
`ifdef SR_DRIVER_MIRROR_EN
  logic q_mirror;
`endif

  int n_checks = 0;
  int n_fail = 0;

  button_sr_driver #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_set  (bs),
    .btn_reset(br),
    .s        (s),
    .r        (r),
    .conflict (conflict)
`ifdef SR_DRIVER_MIRROR_EN
    ,
    .q_mirror (q_mirror)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bs = 1'b0;
    br = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_q(input string tag, input logic exp);
`ifdef SR_DRIVER_MIRROR_EN
    chk(tag, q_mirror, exp);
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick();
    chk("rst_s", s, 1'b0);
    chk("rst_r", r, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    chk_q("rst_q", 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Clean set press held
    bs = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      chk($sformatf("set_s c%0d", n), s, (n == 7 || n == 8));
      chk($sformatf("set_r c%0d", n), r, 1'b0);
      chk($sformatf("set_cf c%0d", n), conflict, 1'b0);
      chk_q($sformatf("set_q c%0d", n), (n >= 7));
    end
    idle(15);

    // Bouncing input never qualifies
    for (int n = 0; n < 30; n++) begin
      bs = (n < 20) ? ~bs : 1'b0;
      tick();
      chk($sformatf("bounce_s c%0d", n), s, 1'b0);
      chk($sformatf("bounce_r c%0d", n), r, 1'b0);
      chk($sformatf("bounce_cf c%0d", n), conflict, 1'b0);
    end
    idle(15);

    // Simultaneous presses
    bs = 1'b1;
    br = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      chk($sformatf("simul_cf c%0d", n), conflict, (n == 7));
      chk($sformatf("simul_s c%0d", n), s, 1'b0);
      chk($sformatf("simul_r c%0d", n), r, 1'b0);
    end
    idle(15);

    // Reset press one cycle behind set press
    bs = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (n == 0) br = 1'b1;
      chk($sformatf("late_s c%0d", n), s, (n == 7 || n == 8));
      chk($sformatf("late_r c%0d", n), r, 1'b0);
      chk($sformatf("late_cf c%0d", n), conflict, (n == 8));
    end
    idle(15);

    // Reset asserted mid-pulse
    bs = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("abort_s_before", s, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_s_async", s, 1'b0);
    chk_q("abort_q_async", 1'b0);
    bs = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      tick();
      chk($sformatf("abort_idle_s c%0d", n), s, 1'b0);
    end

    // Set then reset: mirror follows and pulses never overlap
    bs = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("seq1_s c%0d", n), s, (n == 7 || n == 8));
      chk($sformatf("seq1_ovl c%0d", n), s & r, 1'b0);
      chk_q($sformatf("seq1_q c%0d", n), (n >= 7));
    end
    bs = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      chk($sformatf("gap_s c%0d", n), s, 1'b0);
      chk($sformatf("gap_r c%0d", n), r, 1'b0);
    end
    br = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      chk($sformatf("seq2_r c%0d", n), r, (n == 7 || n == 8));
      chk($sformatf("seq2_s c%0d", n), s, 1'b0);
      chk($sformatf("seq2_ovl c%0d", n), s & r, 1'b0);
      chk_q($sformatf("seq2_q c%0d", n), (n < 7));
    end
    idle(15);

    // Button held across reset release needs a full debounce
    bs = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    rst_n = 1'b0;
    #1;
    chk("held_rst_s", s, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("held_s c%0d", n), s, (n == 7 || n == 8));
      chk($sformatf("held_cf c%0d", n), conflict, 1'b0);
    end
    idle(15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
